// File: rtl/reaction_timer_ctrl_pkg.sv
// rtl/reaction_timer_ctrl_pkg.sv - shared state encodings and defaults for the reaction timer
package reaction_timer_ctrl_pkg;

   localparam int CNT_W_DEF      = 15;
   localparam int MAX_MS_DEF     = 9999;
   localparam int RND_DELAY_BITS = 12;

   // Sequencer state encodings, fixed so a logic analyser trace stays readable
   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_WAIT_RND    = 3'd1;
   localparam logic [2:0] ST_DELAY       = 3'd2;
   localparam logic [2:0] ST_GO          = 3'd3;
   localparam logic [2:0] ST_RESULT      = 3'd4;
   localparam logic [2:0] ST_FALSE_START = 3'd5;

endpackage

// File: rtl/reaction_timer_ctrl_key_press_det.sv
// rtl/reaction_timer_ctrl_key_press_det.sv - one-bit falling-edge detector for an active-low key
module key_press_det (
   input  logic i_clk,
   input  logic i_resetn,
   input  logic i_key,
   output logic o_press
);

   logic r_prev;

   // Remember last cycle's key level; reset to released so no spurious press
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_prev <= 1'b1;
      end else begin
         r_prev <= i_key;
      end
   end

   // A press is the cycle where the key is low but was high one cycle earlier
   assign o_press = r_prev & ~i_key;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// rtl/reaction_timer_ctrl.sv - sequencing FSM for the reaction-timer datapath
module reaction_timer_ctrl
   import reaction_timer_ctrl_pkg::*;
#(
   parameter int MIN_DELAY_MS = 1000,
   parameter int MAX_MS       = MAX_MS_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic             CLOCK_50,
   input  logic             KEY0,
   input  logic             ms_tick,
   input  logic             start_n,
   input  logic             react_n,
   input  logic [CNT_W-1:0] rnd_value,
   input  logic             rnd_ready,
   output logic             rnd_req,
   output logic             led_go,
   output logic [CNT_W-1:0] disp_val,
   output logic [CNT_W-1:0] best_val,
   output logic             false_start,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] LP_MIN    = CNT_W'(MIN_DELAY_MS);
   localparam logic [CNT_W-1:0] LP_MAX    = CNT_W'(MAX_MS);
   localparam logic [CNT_W-1:0] LP_MAX_M1 = CNT_W'(MAX_MS - 1);
   localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_dly_cnt;
   logic [CNT_W-1:0] r_rx_cnt;
   logic [CNT_W-1:0] r_disp;
   logic [CNT_W-1:0] r_best;
   logic             r_rnd_req;
   logic             r_led_go;
   logic             r_false_start;
   logic             r_timeout;

   logic             w_start_press;
   logic             w_react_press;
   logic [CNT_W-1:0] w_rnd_delay;
   logic             w_unused_rnd;

   key_press_det u_start_det (
      .i_clk    (CLOCK_50),
      .i_resetn (KEY0),
      .i_key    (start_n),
      .o_press  (w_start_press)
   );

   key_press_det u_react_det (
      .i_clk    (CLOCK_50),
      .i_resetn (KEY0),
      .i_key    (react_n),
      .o_press  (w_react_press)
   );

   // Only the low bits of the random word set the variable part of the delay
   assign w_rnd_delay  = LP_MIN + {{(CNT_W - RND_DELAY_BITS){1'b0}}, rnd_value[RND_DELAY_BITS-1:0]};
   assign w_unused_rnd = ^rnd_value[CNT_W-1:RND_DELAY_BITS];

   // Round sequencer: request random, delay, light GO, time the reaction
   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         r_state       <= ST_IDLE;
         r_dly_cnt     <= '0;
         r_rx_cnt      <= '0;
         r_disp        <= '0;
         r_best        <= LP_MAX;
         r_rnd_req     <= 1'b0;
         r_led_go      <= 1'b0;
         r_false_start <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_rnd_req <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start_press) begin
                  r_state   <= ST_WAIT_RND;
                  r_rnd_req <= 1'b1;
                  r_disp    <= '0;
               end
            end
            ST_WAIT_RND: begin
               if (rnd_ready) begin
                  r_dly_cnt <= w_rnd_delay;
                  r_state   <= ST_DELAY;
               end
            end
            ST_DELAY: begin
               // An early press beats a same-cycle tick
               if (w_react_press) begin
                  r_state       <= ST_FALSE_START;
                  r_false_start <= 1'b1;
                  r_led_go      <= 1'b0;
               end else if (ms_tick) begin
                  if (r_dly_cnt == LP_ONE) begin
                     r_state  <= ST_GO;
                     r_led_go <= 1'b1;
                     r_rx_cnt <= '0;
                  end else begin
                     r_dly_cnt <= r_dly_cnt - LP_ONE;
                  end
               end
            end
            ST_GO: begin
               // Capture the count as it stood before any same-cycle tick
               if (w_react_press) begin
                  r_state  <= ST_RESULT;
                  r_disp   <= r_rx_cnt;
                  r_led_go <= 1'b0;
                  if (r_rx_cnt < r_best) begin
                     r_best <= r_rx_cnt;
                  end
               end else if (ms_tick) begin
                  if (r_rx_cnt == LP_MAX_M1) begin
                     r_state   <= ST_RESULT;
                     r_disp    <= LP_MAX;
                     r_timeout <= 1'b1;
                     r_led_go  <= 1'b0;
                  end else begin
                     r_rx_cnt <= r_rx_cnt + LP_ONE;
                  end
               end
            end
            ST_RESULT, ST_FALSE_START: begin
               if (w_start_press) begin
                  r_state       <= ST_WAIT_RND;
                  r_rnd_req     <= 1'b1;
                  r_disp        <= '0;
                  r_false_start <= 1'b0;
                  r_timeout     <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rnd_req     = r_rnd_req;
   assign led_go      = r_led_go;
   assign disp_val    = r_disp;
   assign best_val    = r_best;
   assign false_start = r_false_start;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb/tb_reaction_timer_ctrl.sv - self-checking bench for reaction_timer_ctrl
module tb_reaction_timer_ctrl;

   localparam int P_MIN = 2;
   localparam int P_MAX = 20;

   logic        CLOCK_50 = 1'b0;
   logic        KEY0     = 1'b0;
   logic        ms_tick  = 1'b0;
   logic        start_n  = 1'b1;
   logic        react_n  = 1'b1;
   logic [14:0] rnd_value = '0;
   logic        rnd_ready = 1'b0;
   logic        rnd_req;
   logic        led_go;
   logic [14:0] disp_val;
   logic [14:0] best_val;
   logic        false_start;
   logic        timeout;

   int n_checks = 0;
   int n_fail   = 0;
   int tick_phase = 0;
   int ticks_in_go = 0;
   int req_count = 0;
   bit last_tick = 0;

   // Reference model: mode names and counters belong to the bench only
   localparam int M_IDLE = 10, M_ARMING = 11, M_WAITING = 12, M_LIT = 13, M_SHOWN = 14, M_FOUL = 15;
   int m_mode = M_IDLE;
   int m_target = 0;
   int m_elapsed = 0;
   int m_disp = 0;
   int m_best = P_MAX;
   bit m_req = 0, m_led = 0, m_false = 0, m_tmo = 0;
   bit m_prev_s = 1, m_prev_r = 1;

   always #5 CLOCK_50 = ~CLOCK_50;

   reaction_timer_ctrl #(
      .MIN_DELAY_MS (P_MIN),
      .MAX_MS       (P_MAX),
      .CNT_W        (15)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .KEY0        (KEY0),
      .ms_tick     (ms_tick),
      .start_n     (start_n),
      .react_n     (react_n),
      .rnd_value   (rnd_value),
      .rnd_ready   (rnd_ready),
      .rnd_req     (rnd_req),
      .led_go      (led_go),
      .disp_val    (disp_val),
      .best_val    (best_val),
      .false_start (false_start),
      .timeout     (timeout)
   );

   task automatic model_step(input bit rst_n, input bit s_n, input bit r_n, input bit tk,
                             input bit rdy, input logic [14:0] rv);
      bit sp, rp;
      sp = m_prev_s & ~s_n;
      rp = m_prev_r & ~r_n;
      if (!rst_n) begin
         m_mode = M_IDLE; m_disp = 0; m_best = P_MAX;
         m_req = 0; m_led = 0; m_false = 0; m_tmo = 0;
         m_prev_s = 1; m_prev_r = 1;
         return;
      end
      m_prev_s = s_n;
      m_prev_r = r_n;
      m_req = 0;
      if (m_mode == M_IDLE) begin
         if (sp) begin m_mode = M_ARMING; m_req = 1; m_disp = 0; end
      end else if (m_mode == M_ARMING) begin
         if (rdy) begin m_target = P_MIN + (int'(rv) % 4096); m_elapsed = 0; m_mode = M_WAITING; end
      end else if (m_mode == M_WAITING) begin
         if (rp) begin m_mode = M_FOUL; m_false = 1; m_led = 0; end
         else if (tk) begin
            m_elapsed++;
            if (m_elapsed == m_target) begin m_mode = M_LIT; m_led = 1; m_elapsed = 0; end
         end
      end else if (m_mode == M_LIT) begin
         if (rp) begin
            m_mode = M_SHOWN; m_disp = m_elapsed; m_led = 0;
            if (m_elapsed < m_best) m_best = m_elapsed;
         end else if (tk) begin
            m_elapsed++;
            if (m_elapsed == P_MAX) begin m_mode = M_SHOWN; m_disp = P_MAX; m_tmo = 1; m_led = 0; end
         end
      end else begin
         if (sp) begin m_mode = M_ARMING; m_req = 1; m_disp = 0; m_false = 0; m_tmo = 0; end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One clock: tick generator, model update and full output comparison
   task automatic cycle();
      bit pre_led;
      pre_led = led_go;
      ms_tick = (tick_phase == 3);
      @(posedge CLOCK_50);
      model_step(KEY0, start_n, react_n, ms_tick, rnd_ready, rnd_value);
      #1;
      last_tick = ms_tick;
      if (ms_tick && pre_led) ticks_in_go++;
      if (rnd_req === 1'b1) req_count++;
      tick_phase = (tick_phase + 1) % 4;
      n_checks++;
      if (rnd_req !== m_req || led_go !== m_led || disp_val !== 15'(m_disp) ||
          best_val !== 15'(m_best) || false_start !== m_false || timeout !== m_tmo) begin
         n_fail++;
         $display("FAIL model_cycle t=%0t actual/required req=%0b/%0b led=%0b/%0b disp=%0d/%0d best=%0d/%0d fs=%0b/%0b to=%0b/%0b",
                  $time, rnd_req, m_req, led_go, m_led, disp_val, m_disp, best_val, m_best,
                  false_start, m_false, timeout, m_tmo);
      end
   endtask

   task automatic press_start();
      start_n = 1'b0;
      cycle();
      check("rnd_req_pulse", 32'(rnd_req), 1);
      start_n = 1'b1;
      cycle();
      check("rnd_req_single", 32'(rnd_req), 0);
   endtask

   task automatic load_rnd(input logic [14:0] v);
      rnd_value = v;
      rnd_ready = 1'b1;
      cycle();
      rnd_ready = 1'b0;
   endtask

   task automatic wait_go(output int ticks);
      ticks = 0;
      for (int i = 0; i < 2000; i++) begin
         cycle();
         if (last_tick) ticks++;
         if (led_go === 1'b1) break;
      end
      check("go_reached", 32'(led_go), 1);
      ticks_in_go = 0;
   endtask

   task automatic react_until(input int n, input bit coincide);
      for (int i = 0; i < 2000 && ticks_in_go < n; i++) cycle();
      check("react_tick_bound", 32'(ticks_in_go), 32'(n));
      if (coincide) begin
         for (int i = 0; i < 8 && tick_phase != 3; i++) cycle();
      end
      react_n = 1'b0;
      cycle();
      react_n = 1'b1;
      cycle();
   endtask

   typedef struct {
      logic [14:0] rnd;
      int          react_at;     // -1: press during delay, -2: never press
      int          exp_go_ticks;
      int          exp_disp;
      int          exp_best;
      bit          exp_false;
      bit          exp_tmo;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int t;
      vecs[0] = '{15'd3,      7,  5, 7,  7, 1'b0, 1'b0};
      vecs[1] = '{15'd1,      12, 3, 12, 7, 1'b0, 1'b0};
      vecs[2] = '{15'h1002,   5,  4, 5,  5, 1'b0, 1'b0};
      vecs[3] = '{15'd0,      -1, 0, 0,  5, 1'b1, 1'b0};
      vecs[4] = '{15'd4,      -2, 6, 20, 5, 1'b0, 1'b1};

      // Reset state
      KEY0 = 1'b0;
      cycle();
      cycle();
      KEY0 = 1'b1;
      check("rst_disp", 32'(disp_val), 0);
      check("rst_best", 32'(best_val), P_MAX);
      check("rst_led", 32'(led_go), 0);
      check("rst_req", 32'(rnd_req), 0);
      check("rst_fs_to", 32'({false_start, timeout}), 0);

      // React in IDLE does nothing
      react_n = 1'b0; cycle(); react_n = 1'b1; cycle();
      check("idle_react_ignored", 32'({led_go, false_start, disp_val}), 0);

      // Table-driven rounds
      for (int k = 0; k < 5; k++) begin
         req_count = 0;
         press_start();
         load_rnd(vecs[k].rnd);
         if (vecs[k].react_at == -1) begin
            react_n = 1'b0; cycle(); react_n = 1'b1; cycle();
         end else begin
            wait_go(t);
            check("go_tick_count", 32'(t), 32'(vecs[k].exp_go_ticks));
            if (vecs[k].react_at >= 0) begin
               react_until(vecs[k].react_at, 1'b0);
            end else begin
               for (int i = 0; i < 1000 && timeout !== 1'b1; i++) cycle();
            end
         end
         check("tbl_disp", 32'(disp_val), 32'(vecs[k].exp_disp));
         check("tbl_best", 32'(best_val), 32'(vecs[k].exp_best));
         check("tbl_false", 32'(false_start), 32'(vecs[k].exp_false));
         check("tbl_timeout", 32'(timeout), 32'(vecs[k].exp_tmo));
         check("tbl_led_off", 32'(led_go), 0);
         check("tbl_req_count", 32'(req_count), 1);
      end

      // Press coincident with the tick that would take the count from 6 to 7
      press_start();
      load_rnd(15'd0);
      wait_go(t);
      react_until(6, 1'b1);
      check("coincide_disp", 32'(disp_val), 6);
      check("coincide_best", 32'(best_val), 5);

      // Held start and mid-GO start presses are ignored
      req_count = 0;
      start_n = 1'b0;
      cycle();
      check("held_req", 32'(rnd_req), 1);
      cycle();
      check("held_no_req", 32'(rnd_req), 0);
      load_rnd(15'd1);
      wait_go(t);
      check("held_go_ticks", 32'(t), 3);
      start_n = 1'b1; cycle();
      start_n = 1'b0; cycle();
      check("go_start_no_req", 32'(rnd_req), 0);
      check("go_start_led", 32'(led_go), 1);
      start_n = 1'b1;
      react_until(4, 1'b0);
      check("ignored_disp", 32'(disp_val), 4);
      check("ignored_best", 32'(best_val), 4);
      check("ignored_req_count", 32'(req_count), 1);

      // Reset in the middle of GO
      press_start();
      load_rnd(15'd2);
      wait_go(t);
      cycle();
      KEY0 = 1'b0;
      cycle();
      KEY0 = 1'b1;
      check("midrst_led", 32'(led_go), 0);
      check("midrst_disp", 32'(disp_val), 0);
      check("midrst_best", 32'(best_val), P_MAX);
      press_start();

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         KEY0      = ($urandom_range(0, 299) != 0);
         start_n   = ($urandom_range(0, 7) != 0);
         react_n   = ($urandom_range(0, 15) != 0);
         rnd_ready = ($urandom_range(0, 3) == 0);
         rnd_value = 15'($urandom) & 15'h700F;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
- Sequencing FSM for the lab 2 reaction-timer datapath.
- Requests a value from the random generator and turns it into a random millisecond delay.
- Lights the GO LED, then counts milliseconds until the player presses the react key.
- Drives the 15-bit value consumed by bin2BCD/num_decoder and keeps a best-time register.
- Sits between the msec clock_divider tick, the random block and the display path.

Parameters:
- MIN_DELAY_MS, 1000: fixed part of the pre-GO delay, in ms. Must be >= 1.
- MAX_MS, 9999: reaction-count saturation and timeout value. Must fit 4 BCD digits.
- CNT_W, 15: width of all ms counters and display values.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- KEY0  in  1  synchronous active-low reset.
- ms_tick  in  1  one-cycle strobe per millisecond, CLOCK_50 domain.
- start_n  in  1  start key, active-low, synchronised and debounced upstream.
- react_n  in  1  react key, active-low, synchronised and debounced upstream.
- rnd_value  in  15  random generator output.
- rnd_ready  in  1  rnd_value valid.
- rnd_req  out  1  one-cycle request pulse to the random generator.
- led_go  out  1  GO indicator.
- disp_val  out  15  value to bin2BCD.
- best_val  out  15  best (lowest) reaction time this power-up.
- false_start  out  1  react key pressed before GO.
- timeout  out  1  no press before MAX_MS.

Behaviour:
- Reset, synchronous: applied on the CLOCK_50 edge where KEY0=0, aborts any round.
  - state=IDLE.
  - rnd_req, led_go, false_start and timeout = 0.
  - disp_val = 0; best_val = MAX_MS.
  - Edge-detect history registers = 1 (released).
- Press detection: press = prev & ~key, where prev is the key registered on the previous cycle. A held key produces exactly one press.
- All outputs are registered and change on the edge at which the press or tick is sampled.
- IDLE:
  - start press -> WAIT_RND, rnd_req=1 for exactly one cycle, disp_val=0.
  - react press is ignored.
- WAIT_RND:
  - On rnd_ready=1 -> load dly_cnt = MIN_DELAY_MS + rnd_value[11:0], giving 1000..5095 ms at default; go to DELAY.
  - All presses are ignored.
- DELAY:
  - Each ms_tick decrements dly_cnt. A tick while dly_cnt==1 -> GO, led_go=1, rx_cnt=0.
  - React press -> FALSE_START, false_start=1, led_go=0. The press has priority over a same-cycle tick.
- GO:
  - Each ms_tick increments rx_cnt.
  - React press -> RESULT, disp_val = rx_cnt value before any same-cycle tick, led_go=0.
  - In the same cycle, best_val = min(best_val, captured value); equality leaves it unchanged.
  - A tick while rx_cnt==MAX_MS-1 -> RESULT, disp_val=MAX_MS, timeout=1, best_val unchanged.
  - A press in that same cycle wins and captures MAX_MS-1.
- RESULT / FALSE_START:
  - Hold all outputs.
  - Start press -> WAIT_RND with rnd_req pulse, disp_val=0, false_start=0, timeout=0.
- Start presses in WAIT_RND, DELAY and GO are ignored, so a round cannot restart mid-measurement.
- rnd_ready asserted outside WAIT_RND is ignored. There is no timeout in WAIT_RND.
- best_val is only reinitialised by KEY0.

Decomposition:
- Shared package/include (reaction_defs):
  - State encodings: IDLE=0, WAIT_RND=1, DELAY=2, GO=3, RESULT=4, FALSE_START=5, in 3 bits.
  - CNT_W default, MAX_MS default, RND_DELAY_BITS=12.
- Sub-module key_press_det: one-bit falling-edge detector with synchronous active-low reset, instantiated for start_n and react_n.

Test Plan:
- Setup for all scenarios: MIN_DELAY_MS=2, ms_tick every 4 cycles.
- Normal round: reset; start press; rnd_value=3 with rnd_ready.
  - -> Exactly one rnd_req pulse.
  - -> led_go rises on the 5th tick after load.
  - -> React after 7 ticks gives disp_val=7 and best_val=7.
- False start: react press during DELAY -> false_start=1, led_go stays 0, disp_val=0, best_val unchanged.
- Best tracking: rounds measuring 7, 12, 5 -> best_val 7, 7, 5.
- Timeout and saturation: MAX_MS=20, no react press -> disp_val=20, timeout=1, best_val unchanged.
- Simultaneous events: react press coincident with the ms_tick that would bring rx_cnt from 6 to 7 -> disp_val=6.
- Reset mid-GO: KEY0 low for one cycle while led_go=1 -> next cycle IDLE, led_go=0, disp_val=0, best_val=MAX_MS.
- Ignored presses: held start_n and start presses during GO -> no rnd_req, measurement continues.
